// File: rtl/dual_issue_scheduler.sv
// Issue-stage controller for the two-pipe core: dual issue, split issue across
// two cycles, or load-use stall, with saturating split/stall counters.
module dual_issue_scheduler #(
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_p1,
    input  logic             valid_p2,
    input  logic [4:0]       rs_p1,
    input  logic [4:0]       rt_p1,
    input  logic [4:0]       rw_p1,
    input  logic [4:0]       rs_p2,
    input  logic [4:0]       rt_p2,
    input  logic [4:0]       rw_p2,
    input  logic             reg_write_p1,
    input  logic             reg_write_p2,
    input  logic             mem_acc_p1,
    input  logic             mem_acc_p2,
    input  logic             branch_p1,
    input  logic             id_ex_mem_read_p1,
    input  logic             id_ex_mem_read_p2,
    input  logic [4:0]       id_ex_rw_p1,
    input  logic [4:0]       id_ex_rw_p2,
    input  logic             ex_flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             issue_p1,
    output logic             issue_p2,
    output logic             split_active,
    output logic [CNT_W-1:0] split_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, SPLIT, LSTALL} state_t;

    // The RUN/SPLIT hazard cycle is the first bubble, so LSTALL covers the rest.
    localparam logic [2:0] LCNT_INIT = 3'((LOAD_USE_STALL > 1) ? (LOAD_USE_STALL - 2) : 0);

    state_t           state_reg, state_next;
    logic [2:0]       lcnt_reg, lcnt_next;
    logic             ret_split_reg, ret_split_next;
    logic [CNT_W-1:0] split_cnt_reg, split_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

    logic       issue_p1_c, issue_p2_c, pc_write_c, if_id_write_c;
    logic       split_inc, stall_inc;
    logic [1:0] idr;
    logic [4:0] idrw [2];
    logic [1:0] hit_rs1, hit_rt1, hit_rs2, hit_rt2;
    logic       lu_p1, lu_p2, split_need;

    assign idr     = {id_ex_mem_read_p2, id_ex_mem_read_p1};
    assign idrw[0] = id_ex_rw_p1;
    assign idrw[1] = id_ex_rw_p2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_idex_pipe
            assign hit_rs1[gi] = idr[gi] && (idrw[gi] != 5'd0) && (idrw[gi] == rs_p1);
            assign hit_rt1[gi] = idr[gi] && (idrw[gi] != 5'd0) && (idrw[gi] == rt_p1);
            assign hit_rs2[gi] = idr[gi] && (idrw[gi] != 5'd0) && (idrw[gi] == rs_p2);
            assign hit_rt2[gi] = idr[gi] && (idrw[gi] != 5'd0) && (idrw[gi] == rt_p2);
        end
    endgenerate

    assign lu_p1 = valid_p1 && (|hit_rs1 || |hit_rt1);
    assign lu_p2 = valid_p2 && (|hit_rs2 || |hit_rt2);

    assign split_need = valid_p1 && valid_p2 && (
        (reg_write_p1 && (rw_p1 != 5'd0) && ((rw_p1 == rs_p2) || (rw_p1 == rt_p2))) ||
        (reg_write_p1 && reg_write_p2 && (rw_p1 == rw_p2) && (rw_p1 != 5'd0)) ||
        (mem_acc_p1 && mem_acc_p2) ||
        branch_p1);

    always_comb begin
        state_next     = state_reg;
        lcnt_next      = lcnt_reg;
        ret_split_next = ret_split_reg;
        issue_p1_c     = 1'b0;
        issue_p2_c     = 1'b0;
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        split_inc      = 1'b0;
        stall_inc      = 1'b0;
        if (ex_flush) begin
            pc_write_c     = 1'b1;
            if_id_write_c  = 1'b1;
            state_next     = RUN;
            lcnt_next      = 3'd0;
            ret_split_next = 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (lu_p1 || lu_p2) begin
                        stall_inc = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            lcnt_next      = LCNT_INIT;
                            ret_split_next = 1'b0;
                            state_next     = LSTALL;
                        end
                    end else if (split_need) begin
                        issue_p1_c = 1'b1;
                        split_inc  = 1'b1;
                        state_next = SPLIT;
                    end else begin
                        issue_p1_c    = valid_p1;
                        issue_p2_c    = valid_p2;
                        pc_write_c    = 1'b1;
                        if_id_write_c = 1'b1;
                    end
                end
                SPLIT: begin
                    // Only the held slot-2 instruction remains to be checked.
                    if (lu_p2) begin
                        stall_inc = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            lcnt_next      = LCNT_INIT;
                            ret_split_next = 1'b1;
                            state_next     = LSTALL;
                        end
                    end else begin
                        issue_p2_c    = valid_p2;
                        pc_write_c    = 1'b1;
                        if_id_write_c = 1'b1;
                        state_next    = RUN;
                    end
                end
                LSTALL: begin
                    stall_inc = 1'b1;
                    if (lcnt_reg == 3'd0) begin
                        state_next = ret_split_reg ? SPLIT : RUN;
                    end else begin
                        lcnt_next = lcnt_reg - 3'd1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign split_cnt_next = (split_inc && (split_cnt_reg != {CNT_W{1'b1}})) ? split_cnt_reg + 1'b1 : split_cnt_reg;
    assign stall_cnt_next = (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}})) ? stall_cnt_reg + 1'b1 : stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            lcnt_reg      <= 3'd0;
            ret_split_reg <= 1'b0;
            split_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            lcnt_reg      <= lcnt_next;
            ret_split_reg <= ret_split_next;
            split_cnt_reg <= split_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Enables must stay low for the whole reset window, not just after the first edge.
    assign pc_write     = rst_n & pc_write_c;
    assign if_id_write  = rst_n & if_id_write_c;
    assign issue_p1     = rst_n & issue_p1_c;
    assign issue_p2     = rst_n & issue_p2_c;
    assign split_active = rst_n & (state_reg == SPLIT);
    assign split_cnt    = split_cnt_reg;
    assign stall_cnt    = stall_cnt_reg;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed table-driven bench for dual_issue_scheduler (LOAD_USE_STALL=3, CNT_W=4).
module tb_dual_issue_scheduler;

    localparam int L = 3;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic valid_p1, valid_p2;
    logic [4:0] rs_p1, rt_p1, rw_p1, rs_p2, rt_p2, rw_p2;
    logic reg_write_p1, reg_write_p2, mem_acc_p1, mem_acc_p2, branch_p1;
    logic id_ex_mem_read_p1, id_ex_mem_read_p2;
    logic [4:0] id_ex_rw_p1, id_ex_rw_p2;
    logic ex_flush;
    logic pc_write, if_id_write, issue_p1, issue_p2, split_active;
    logic [W-1:0] split_cnt, stall_cnt;

    always #5 clk = ~clk;

    dual_issue_scheduler #(.LOAD_USE_STALL(L), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_p1(valid_p1), .valid_p2(valid_p2),
        .rs_p1(rs_p1), .rt_p1(rt_p1), .rw_p1(rw_p1),
        .rs_p2(rs_p2), .rt_p2(rt_p2), .rw_p2(rw_p2),
        .reg_write_p1(reg_write_p1), .reg_write_p2(reg_write_p2),
        .mem_acc_p1(mem_acc_p1), .mem_acc_p2(mem_acc_p2), .branch_p1(branch_p1),
        .id_ex_mem_read_p1(id_ex_mem_read_p1), .id_ex_mem_read_p2(id_ex_mem_read_p2),
        .id_ex_rw_p1(id_ex_rw_p1), .id_ex_rw_p2(id_ex_rw_p2),
        .ex_flush(ex_flush),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .issue_p1(issue_p1), .issue_p2(issue_p2), .split_active(split_active),
        .split_cnt(split_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic       v1, v2;
        logic [4:0] rs1, rt1, rw1, rs2, rt2, rw2;
        logic       we1, we2, m1, m2, br, idr1, idr2;
        logic [4:0] idrw1, idrw2;
        logic       fl;
        logic [4:0] exp_o;   // {issue_p1, issue_p2, pc_write, if_id_write, split_active}
        logic [W-1:0] exp_sc, exp_st;
    } vec_t;

    localparam int NV = 25;
    vec_t vt [NV];
    int n_applied = 0;
    int n_miss    = 0;

    // Independent pair with no hazards of any kind.
    function automatic vec_t base();
        vec_t v;
        v.v1 = 1; v.v2 = 1;
        v.rs1 = 5'd1; v.rt1 = 5'd2; v.rw1 = 5'd3;
        v.rs2 = 5'd4; v.rt2 = 5'd5; v.rw2 = 5'd6;
        v.we1 = 1; v.we2 = 1; v.m1 = 0; v.m2 = 0; v.br = 0;
        v.idr1 = 0; v.idr2 = 0; v.idrw1 = 5'd0; v.idrw2 = 5'd0; v.fl = 0;
        v.exp_o = 5'b0; v.exp_sc = '0; v.exp_st = '0;
        return v;
    endfunction

    function automatic vec_t ex(vec_t vin, logic [4:0] o, int sc, int st);
        vec_t v;
        v = vin;
        v.exp_o  = o;
        v.exp_sc = W'(sc);
        v.exp_st = W'(st);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        valid_p1 = v.v1; valid_p2 = v.v2;
        rs_p1 = v.rs1; rt_p1 = v.rt1; rw_p1 = v.rw1;
        rs_p2 = v.rs2; rt_p2 = v.rt2; rw_p2 = v.rw2;
        reg_write_p1 = v.we1; reg_write_p2 = v.we2;
        mem_acc_p1 = v.m1; mem_acc_p2 = v.m2; branch_p1 = v.br;
        id_ex_mem_read_p1 = v.idr1; id_ex_mem_read_p2 = v.idr2;
        id_ex_rw_p1 = v.idrw1; id_ex_rw_p2 = v.idrw2;
        ex_flush = v.fl;
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
        n_applied++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got o=%b sc=%0d st=%0d, expected o=%b sc=%0d st=%0d",
                     name, act[13:8], act[7:4], act[3:0], req[13:8], req[7:4], req[3:0]);
        end else begin
            $display("ok   %s: o=%b sc=%0d st=%0d", name, act[13:8], act[7:4], act[3:0]);
        end
    endtask

    function automatic logic [13:0] outs();
        return {1'b0, issue_p1, issue_p2, pc_write, if_id_write, split_active, split_cnt, stall_cnt};
    endfunction

    initial begin
        vec_t v;
        // Cycle-by-cycle table; each row is checked before the clock edge it precedes.
        v = base();                                   vt[0]  = ex(v, 5'b11110, 0, 0);
        v = base();                                   vt[1]  = ex(v, 5'b11110, 0, 0);
        v = base(); v.rw1 = 8; v.rs2 = 8;             vt[2]  = ex(v, 5'b10000, 0, 0);
        v = base(); v.rw1 = 8; v.rs2 = 8;             vt[3]  = ex(v, 5'b01111, 1, 0);
        v = base(); v.rw1 = 0; v.rs2 = 0;             vt[4]  = ex(v, 5'b11110, 1, 0);
        v = base(); v.m1 = 1; v.m2 = 1;               vt[5]  = ex(v, 5'b10000, 1, 0);
        v = base(); v.m1 = 1; v.m2 = 1; v.idr1 = 1; v.idrw1 = 4;
                                                      vt[6]  = ex(v, 5'b00001, 2, 0);
        v = base(); v.m1 = 1; v.m2 = 1;               vt[7]  = ex(v, 5'b00000, 2, 1);
        v = base(); v.m1 = 1; v.m2 = 1;               vt[8]  = ex(v, 5'b00000, 2, 2);
        v = base(); v.m1 = 1; v.m2 = 1;               vt[9]  = ex(v, 5'b01111, 2, 3);
        v = base(); v.rt1 = 9; v.idr2 = 1; v.idrw2 = 9;
                                                      vt[10] = ex(v, 5'b00000, 2, 3);
        v = base(); v.rt1 = 9;                        vt[11] = ex(v, 5'b00000, 2, 4);
        v = base(); v.rt1 = 9;                        vt[12] = ex(v, 5'b00000, 2, 5);
        v = base(); v.rt1 = 9;                        vt[13] = ex(v, 5'b11110, 2, 6);
        v = base(); v.rw1 = 7; v.rw2 = 7;             vt[14] = ex(v, 5'b10000, 2, 6);
        v = base(); v.rw1 = 7; v.rw2 = 7; v.fl = 1;   vt[15] = ex(v, 5'b00111, 3, 6);
        v = base();                                   vt[16] = ex(v, 5'b11110, 3, 6);
        v = base(); v.br = 1;                         vt[17] = ex(v, 5'b10000, 3, 6);
        v = base(); v.br = 1;                         vt[18] = ex(v, 5'b01111, 4, 6);
        v = base(); v.v1 = 0; v.rw1 = 8; v.rs2 = 8;   vt[19] = ex(v, 5'b01110, 4, 6);
        v = base(); v.v1 = 0; v.rs1 = 12; v.idr1 = 1; v.idrw1 = 12;
                                                      vt[20] = ex(v, 5'b01110, 4, 6);
        v = base(); v.idr1 = 1; v.idrw1 = 5;          vt[21] = ex(v, 5'b00000, 4, 6);
        v = base(); v.fl = 1;                         vt[22] = ex(v, 5'b00110, 4, 7);
        v = base();                                   vt[23] = ex(v, 5'b11110, 4, 7);
        v = base(); v.rs1 = 0; v.idr2 = 1; v.idrw2 = 0;
                                                      vt[24] = ex(v, 5'b11110, 4, 7);

        // Reset state: enables held low even though inputs describe an issuable pair.
        rst_n = 1'b0;
        drive(base());
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 14'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            #1;
            check($sformatf("vec%0d", i), outs(), {1'b0, vt[i].exp_o, vt[i].exp_sc, vt[i].exp_st});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a load-use stall.
        v = base(); v.rt1 = 9; v.idr2 = 1; v.idrw2 = 9;
        drive(v);
        @(posedge clk); #1;
        v.idr2 = 0;
        drive(v);
        #1;
        check("lstall_entered", outs(), {1'b0, 5'b00000, 4'd4, 4'd8});
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_lstall", outs(), 14'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("run_after_reset", outs(), {1'b0, 5'b11110, 4'd0, 4'd0});

        // Held load-use hazard keeps stalling; stall_cnt must stop at 15.
        v = base(); v.rt1 = 9; v.idr2 = 1; v.idrw2 = 9;
        drive(v);
        repeat (18) @(posedge clk);
        #1;
        check("stall_saturate", outs(), {1'b0, 5'b00000, 4'd0, 4'd15});

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        v = base(); v.rw1 = 8; v.rs2 = 8;
        drive(v);
        #1;
        check("split_after_reset", outs(), {1'b0, 5'b10000, 4'd0, 4'd0});
        repeat (40) @(posedge clk);
        #1;
        check("split_saturate", outs(), {1'b0, 5'b10000, 4'd15, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
